dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, defaults,
// and the access-error rule used by the responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_LATENCY     = 2;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;

  // Misaligned word access or word index beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide data array: one synchronous write port, one asynchronous read
// port, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Synchronous word write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency,
// error flagging and a pipeline stall output.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic        gap_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        idle;
  logic        accept;
  logic        src_we;
  logic [31:0] src_addr;
  logic        src_err;
  logic        arr_we;
  logic [31:0] rd_data;
  logic [31:0] rsp_rdata_d;

  assign idle        = (state_q == IDLE);
  // gap_q holds ready low for the one IDLE cycle that follows a consumed response.
  assign req_ready_o = idle && !gap_q && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  // In IDLE the live request is the one about to be captured, so the same
  // error term serves store gating at acceptance and the latency-1 response.
  // Store data is committed at acceptance, so it is never held in a register.
  assign src_we      = idle ? req_we_i : we_q;
  assign src_addr    = idle ? req_addr_i : addr_q;
  assign src_err     = addr_err(src_addr, DEPTH_WORDS);
  assign arr_we      = accept && src_we && !src_err;
  assign rsp_rdata_d = (src_we || src_err) ? '0 : rd_data;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .waddr_i (src_addr[AW+1:2]),
    .wdata_i (req_wdata_i),
    .raddr_i (src_addr[AW+1:2]),
    .rdata_o (rd_data)
  );

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      gap_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q   <= req_we_i;
            addr_q <= req_addr_i;
            if (LATENCY <= 1) begin
              state_q     <= RESP;
              cnt_q       <= '0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= src_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= src_err;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            gap_q       <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign stall_o     = (req_valid_i && !req_ready_o) || ((state_q == RESP) && !rsp_ready_i);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized loads/stores against a
// word-array reference model, plus reset, hold and latency-1 throughput cases.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, stall_o;
  logic [31:0] rsp_rdata_o;

  logic        b_valid, b_ready_o, b_we, b_rsp_valid, b_rsp_ready, b_err, b_stall;
  logic [31:0] b_addr, b_wdata, b_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .stall_o(stall_o)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(b_valid), .req_ready_o(b_ready_o), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rdata), .rsp_err_o(b_err), .stall_o(b_stall)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [DEPTH];
  int unsigned cyc = 0;
  int          passes = 0;
  int          total = 0;
  int unsigned rdy_mode = 0;  // 0 random, 1 held low

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    else passes++;
  endtask

  // Response-ready driver.
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready_i = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end
  end

  // Present a request until accepted; model result computed at acceptance.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit push);
    exp_t e;
    logic err;
    bit   ok = 0;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end else begin
      err = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
      if (we && !err) mem[addr[9:2]] = wd;
      e.rdata = (we || err) ? 32'h0 : mem[addr[9:2]];
      e.err   = err;
      e.acc   = cyc + 1;
      if (push) q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_we_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid_o) return;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    logic [31:0] w = $urandom_range(0, 16);
    logic [31:0] t;
    if (w == 16) w = 255;
    t = {w[29:0], 2'b00};
    if (k == 7) t[1:0] = 2'($urandom_range(1, 3));
    if (k == 8) begin t = $urandom; t[10] = 1'b1; t[1:0] = 2'b00; end
    if (k == 9) t = 32'h400;
    return t;
  endfunction

  // Monitor: pops one expectation per response and checks it while it is held.
  initial begin
    exp_t cur;
    bit   in_rsp = 0;
    cur.rdata = '0; cur.err = 1'b0; cur.acc = 0;
    forever begin
      @(negedge clk);
      if (rst_i) in_rsp = 0;
      else if (rsp_valid_o) begin
        if (!in_rsp) begin
          chk("rsp_expected", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            cur = q.pop_front();
            chk("latency", cyc - cur.acc, LAT);
          end
          in_rsp = 1;
        end
        chk("rdata", rsp_rdata_o, cur.rdata);
        chk("err", 32'(rsp_err_o), 32'(cur.err));
        chk("ready_in_resp", 32'(req_ready_o), 32'd0);
        chk("stall_in_resp", 32'(stall_o), 32'(req_valid_i || !rsp_ready_i));
        if (rsp_ready_i) in_rsp = 0;
      end
    end
  end

  initial begin
    int unsigned last;
    int unsigned nrsp;
    bit          seen;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready_o), 32'd1);

    for (int w = 0; w < 17; w++) begin
      logic [31:0] a = (w == 16) ? 32'h3FC : 32'(w * 4);
      do_req(1'b1, a, $urandom, 1);
    end

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 1);
    do_req(1'b0, 32'h10, 32'h0, 1);
    do_req(1'b0, 32'h13, 32'h0, 1);
    do_req(1'b1, 32'h400, 32'h12345678, 1);
    do_req(1'b0, 32'h0, 32'h0, 1);

    for (int i = 0; i < 80; i++) do_req(1'($urandom), rand_addr(), $urandom, 1);
    drain();

    // Response held for 5 cycles.
    rdy_mode = 1;
    do_req(1'b0, 32'h10, 32'h0, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid_o;
    end
    chk("hold_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_stall", 32'(stall_o), 32'd1);
      chk("hold_ready", 32'(req_ready_o), 32'd0);
    end
    rdy_mode = 0;
    drain();

    // Reset mid-WAIT after a committed store: no response, store persists.
    do_req(1'b1, 32'h14, 32'hCAFEF00D, 0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(rsp_valid_o), 32'd0);
    chk("midrst_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 32'(req_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    do_req(1'b0, 32'h14, 32'h0, 1);
    drain();

    // Latency-1 instance: store word 0, then continuous loads.
    @(posedge clk); #1;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h0; b_wdata = 32'h0BADCAFE;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = b_ready_o;
    end
    chk("l1_accept", 32'(seen), 32'd1);
    @(posedge clk); #1 b_we = 1'b0;
    nrsp = 0; last = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (b_rsp_valid) begin
        chk("l1_err", 32'(b_err), 32'd0);
        chk("l1_rdata", b_rdata, (nrsp == 0) ? 32'h0 : 32'h0BADCAFE);
        if (nrsp > 0) chk("l1_spacing", cyc - last, 32'd3);
        last = cyc;
        nrsp++;
      end
    end
    chk("l1_count", 32'(nrsp >= 6), 32'd1);
    b_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
